max_finder_set: RTL and testbench

MAX_FINDER_SET -- requirements
Module: max_finder_set

---
 rtl/max_finder_set.sv | 98 +++++++++
 tb/tb_max_finder_set.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/max_finder_set.sv
// Pipelined maximum finder over N packed unsigned elements.
// A binary comparator tree with a register stage after every level reports
// the largest element and its index max(1, clog2(N)) cycles after the input.
// The tree is padded to a power of two with zero-valued slots. The lower
// index wins ties, so a real element always beats a padded slot.
module max_finder_set #(
  parameter int width = 4,
  parameter int N = 32,
  localparam int PW = (N <= 2) ? 1 : $clog2(N),
  localparam int L = (N <= 2) ? 1 : $clog2(N)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  input  logic [width*N-1:0]   in,
  output logic [width-1:0]     out,
  output logic [PW-1:0]        pos,
  output logic                 out_valid
);

  // Padded leaf count; the tree is stored heap-style with the root at node 1.
  // Node n has children 2n (lower element indices) and 2n+1.
  localparam int P = 1 << L;

  logic [width*P-1:0] padded;

  // Combined view of every node that feeds a comparator:
  // registered internal nodes 2..P-1 and combinational leaves P..2P-1.
  logic [width-1:0] allv [2:2*P-1];
  logic [PW-1:0]    alli [2:2*P-1];

  // Comparator results and the registered internal nodes 1..P-1.
  logic [width-1:0] winv  [1:P-1];
  logic [PW-1:0]    wini  [1:P-1];
  logic [width-1:0] nodev [1:P-1];
  logic [PW-1:0]    nodei [1:P-1];

  logic [L-1:0] vpipe;

  // Gather leaves (zero-padded past N) and internal registers into one node array
  always_comb begin
    padded = '0;
    padded[width*N-1:0] = in;
    for (int i = 0; i < P; i++) begin
      allv[P+i] = padded[width*i +: width];
      alli[P+i] = PW'(i);
    end
    for (int n = 2; n < P; n++) begin
      allv[n] = nodev[n];
      alli[n] = nodei[n];
    end
  end

  // Each node picks the larger child, keeping the lower-index child on a tie
  always_comb begin
    for (int n = 1; n < P; n++) begin
      if (allv[2*n] >= allv[2*n+1]) begin
        winv[n] = allv[2*n];
        wini[n] = alli[2*n];
      end else begin
        winv[n] = allv[2*n+1];
        wini[n] = alli[2*n+1];
      end
    end
  end

  // Register every comparator output; one tree level per cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int n = 1; n < P; n++) begin
        nodev[n] <= '0;
        nodei[n] <= '0;
      end
    end else begin
      for (int n = 1; n < P; n++) begin
        nodev[n] <= winv[n];
        nodei[n] <= wini[n];
      end
    end
  end

  // Delay in_valid by the tree depth so it lines up with the root register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vpipe <= '0;
    end else begin
      vpipe[0] <= in_valid;
      for (int i = 1; i < L; i++) begin
        vpipe[i] <= vpipe[i-1];
      end
    end
  end

  assign out       = nodev[1];
  assign pos       = nodei[1];
  assign out_valid = vpipe[L-1];

endmodule

// File: tb/tb_max_finder_set.sv
// Self-checking bench for max_finder_set across several width/N configurations.
// Expected results come from a linear-scan reference model and are queued
// with their due cycle when stimulus is driven. Monitors pop and compare them
// when the DUT output is due.
module tb_max_finder_set;

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // Count rising edges so expected results can carry an exact due cycle
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int val;
    int idx;
    int due;
  } exp_t;

  exp_t q8[$], q2[$], q1[$], q32[$], q5[$];

  logic         iv8, iv2, iv1, iv32, iv5;
  logic [31:0]  in8;
  logic [11:0]  in2;
  logic [3:0]   in1;
  logic [127:0] in32;
  logic [19:0]  in5;
  logic [3:0]   out8, out1, out32, out5;
  logic [5:0]   out2;
  logic [2:0]   pos8, pos5;
  logic [0:0]   pos2, pos1;
  logic [4:0]   pos32;
  logic         ov8, ov2, ov1, ov32, ov5;
  logic [127:0] vb;

  max_finder_set #(.width(4), .N(8)) u8 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv8), .in(in8),
    .out(out8), .pos(pos8), .out_valid(ov8));

  max_finder_set #(.width(6), .N(2)) u2 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv2), .in(in2),
    .out(out2), .pos(pos2), .out_valid(ov2));

  max_finder_set #(.width(4), .N(1)) u1 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv1), .in(in1),
    .out(out1), .pos(pos1), .out_valid(ov1));

  max_finder_set #(.width(4), .N(32)) u32 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv32), .in(in32),
    .out(out32), .pos(pos32), .out_valid(ov32));

  max_finder_set #(.width(4), .N(5)) u5 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv5), .in(in5),
    .out(out5), .pos(pos5), .out_valid(ov5));

  // Linear scan: first strictly larger element wins, so ties keep the lowest index
  function automatic exp_t refMax(input logic [127:0] vec, input int w,
                                  input int n, input int lat);
    exp_t e;
    int   v;
    e.val = -1;
    e.idx = 0;
    for (int i = 0; i < n; i++) begin
      v = 0;
      for (int b = 0; b < w; b++) v = v | (int'(vec[i*w+b]) << b);
      if (v > e.val) begin
        e.val = v;
        e.idx = i;
      end
    end
    e.due = cyc + lat;
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus8(input logic [31:0] v);
    in8 = v; iv8 = 1'b1; q8.push_back(refMax(128'(v), 4, 8, 3));
  endtask

  task automatic applyStimulus2(input logic [11:0] v);
    in2 = v; iv2 = 1'b1; q2.push_back(refMax(128'(v), 6, 2, 1));
  endtask

  task automatic applyStimulus1(input logic [3:0] v);
    in1 = v; iv1 = 1'b1; q1.push_back(refMax(128'(v), 4, 1, 1));
  endtask

  task automatic applyStimulus32(input logic [127:0] v);
    in32 = v; iv32 = 1'b1; q32.push_back(refMax(v, 4, 32, 5));
  endtask

  task automatic applyStimulus5(input logic [19:0] v);
    in5 = v; iv5 = 1'b1; q5.push_back(refMax(128'(v), 4, 5, 3));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    iv8 = 1'b0; iv2 = 1'b0; iv1 = 1'b0; iv32 = 1'b0; iv5 = 1'b0;
  endtask

  task automatic flushAll();
    q8.delete(); q2.delete(); q1.delete(); q32.delete(); q5.delete();
  endtask

  // Width 4, N 8 monitor: result due exactly L cycles after input, nothing else valid
  always @(negedge clk) begin
    if (q8.size() > 0 && q8[0].due == cyc) begin
      checkOutput("n8 out_valid", 32'(ov8), 1);
      checkOutput("n8 out", 32'(out8), q8[0].val);
      checkOutput("n8 pos", 32'(pos8), q8[0].idx);
      void'(q8.pop_front());
    end else if (ov8 !== 1'b0) begin
      checkOutput("n8 spurious out_valid", 32'(ov8), 0);
    end
  end

  // Width 6, N 2 monitor
  always @(negedge clk) begin
    if (q2.size() > 0 && q2[0].due == cyc) begin
      checkOutput("n2 out_valid", 32'(ov2), 1);
      checkOutput("n2 out", 32'(out2), q2[0].val);
      checkOutput("n2 pos", 32'(pos2), q2[0].idx);
      void'(q2.pop_front());
    end else if (ov2 !== 1'b0) begin
      checkOutput("n2 spurious out_valid", 32'(ov2), 0);
    end
  end

  // Width 4, N 1 monitor
  always @(negedge clk) begin
    if (q1.size() > 0 && q1[0].due == cyc) begin
      checkOutput("n1 out_valid", 32'(ov1), 1);
      checkOutput("n1 out", 32'(out1), q1[0].val);
      checkOutput("n1 pos", 32'(pos1), q1[0].idx);
      void'(q1.pop_front());
    end else if (ov1 !== 1'b0) begin
      checkOutput("n1 spurious out_valid", 32'(ov1), 0);
    end
  end

  // Width 4, N 32 monitor
  always @(negedge clk) begin
    if (q32.size() > 0 && q32[0].due == cyc) begin
      checkOutput("n32 out_valid", 32'(ov32), 1);
      checkOutput("n32 out", 32'(out32), q32[0].val);
      checkOutput("n32 pos", 32'(pos32), q32[0].idx);
      void'(q32.pop_front());
    end else if (ov32 !== 1'b0) begin
      checkOutput("n32 spurious out_valid", 32'(ov32), 0);
    end
  end

  // Width 4, N 5 monitor (non-power-of-two, exercises padding)
  always @(negedge clk) begin
    if (q5.size() > 0 && q5[0].due == cyc) begin
      checkOutput("n5 out_valid", 32'(ov5), 1);
      checkOutput("n5 out", 32'(out5), q5[0].val);
      checkOutput("n5 pos", 32'(pos5), q5[0].idx);
      void'(q5.pop_front());
    end else if (ov5 !== 1'b0) begin
      checkOutput("n5 spurious out_valid", 32'(ov5), 0);
    end
  end

  initial begin
    reset_n = 1'b1;
    iv8 = 1'b0; iv2 = 1'b0; iv1 = 1'b0; iv32 = 1'b0; iv5 = 1'b0;
    in8 = '0; in2 = '0; in1 = '0; in32 = '0; in5 = '0;
    for (int i = 0; i < 32; i++) vb[4*i +: 4] = (i == 17) ? 4'h9 : 4'h3;

    // Asynchronous reset with no clock edge yet
    #1 reset_n = 1'b0;
    #1;
    checkOutput("reset n8 out", 32'(out8), 0);
    checkOutput("reset n8 pos", 32'(pos8), 0);
    checkOutput("reset n8 out_valid", 32'(ov8), 0);
    checkOutput("reset n2 out_valid", 32'(ov2), 0);
    checkOutput("reset n1 out_valid", 32'(ov1), 0);
    checkOutput("reset n32 out", 32'(out32), 0);
    checkOutput("reset n32 pos", 32'(pos32), 0);
    checkOutput("reset n32 out_valid", 32'(ov32), 0);
    checkOutput("reset n5 out_valid", 32'(ov5), 0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // N=8: basic max, tie across indices 0-3, all-zero vector
    applyStimulus8(32'habcdef04); tick();
    applyStimulus8(32'h12345670); tick();
    applyStimulus8(32'h0000ffff); tick();
    applyStimulus8(32'h00000000); tick();

    // N=2, width 6
    applyStimulus2(12'b010101010111); tick();
    applyStimulus2(12'b101110000000); tick();
    applyStimulus2(12'b000001111111); tick();

    // N=1
    applyStimulus1(4'h4); tick();
    applyStimulus1(4'hf); tick();
    applyStimulus1(4'h0); tick();

    // N=32, back-to-back
    applyStimulus32(128'h123456789ABCDEF0000555555555FFFF); tick();
    applyStimulus32(vb); tick();

    // N=5: zeros must not report a padded slot, top element, tie at the top
    applyStimulus5(20'h00000); tick();
    applyStimulus5(20'h90000); tick();
    applyStimulus5(20'h99000); tick();

    for (int i = 0; i < 7; i++) tick();

    // Mid-stream reset with three vectors in flight and a valid result showing
    applyStimulus8(32'h00000a00); tick();
    applyStimulus8(32'h00000007); tick();
    applyStimulus8(32'h50000000); tick();
    #2 reset_n = 1'b0;
    flushAll();
    #1;
    checkOutput("midreset n8 out", 32'(out8), 0);
    checkOutput("midreset n8 pos", 32'(pos8), 0);
    checkOutput("midreset n8 out_valid", 32'(ov8), 0);
    tick();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();

    // First accepted vector after reset arrives exactly L cycles later
    applyStimulus8(32'h00f00000); tick();
    for (int i = 0; i < 6; i++) tick();

    checkOutput("drain n8", 32'(q8.size()), 0);
    checkOutput("drain n2", 32'(q2.size()), 0);
    checkOutput("drain n1", 32'(q1.size()), 0);
    checkOutput("drain n32", 32'(q32.size()), 0);
    checkOutput("drain n5", 32'(q5.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
